// File: rtl/rx_buffer_if.sv
// rx_buffer_if: serial receive link plus holding-register handshake.
//   slave  (rx_buffer side): takes din/en/align/rd, drives dout/valid/busy/overrun
//   master (producer/consumer side): the mirror image
interface rx_buffer_if #(
    parameter int WIDTH = 8
);
    logic             din;
    logic             en;
    logic             align;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             busy;
    logic             overrun;

    modport master (
        output din, en, align, rd,
        input  dout, valid, busy, overrun
    );

    modport slave (
        input  din, en, align, rd,
        output dout, valid, busy, overrun
    );
endinterface

// File: rtl/rx_buffer.sv
// rx_buffer: MSB-first serial-to-parallel receiver with a holding register.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - rx_buffer_if.slave
//          din/en   : serial bit and its capture strobe
//          align    : restart word assembly, clears overrun
//          rd       : consumer read, clears valid
//          dout     : last completed word (first bit received lands in the MSB)
//          valid    : holding register holds an unread word
//          busy     : partial word in progress
//          overrun  : sticky, a word overwrote an unread one
module rx_buffer #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    rx_buffer_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-2:0] sreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             overrun_q;

    // Full word formed by the partial bits plus the incoming bit; its low
    // WIDTH-1 bits are also the shifted partial register.
    logic [WIDTH-1:0] word_next;
    assign word_next = {sreg, bus.din};

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            cnt       <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.rd)
                valid_q <= 1'b0;

            if (bus.align) begin
                // Align wins over a completing bit: the bit (if any) starts a new word.
                overrun_q <= 1'b0;
                sreg      <= '0;
                if (bus.en) begin
                    sreg[0] <= bus.din;
                    cnt     <= CW'(1);
                end else begin
                    cnt     <= '0;
                end
            end else if (bus.en) begin
                if (cnt == LAST) begin
                    dout_q  <= word_next;
                    valid_q <= 1'b1;   // overrides the rd clear above
                    cnt     <= '0;
                    sreg    <= '0;
                    if (valid_q && !bus.rd)
                        overrun_q <= 1'b1;
                end else begin
                    sreg <= word_next[WIDTH-2:0];
                    cnt  <= cnt + CW'(1);
                end
            end
        end
    end

    assign bus.dout    = dout_q;
    assign bus.valid   = valid_q;
    assign bus.overrun = overrun_q;
    assign bus.busy    = (cnt != '0);
endmodule

// File: tb/tb_rx_buffer.sv
module tb_rx_buffer;
    logic clk = 1'b0;
    logic rst;

    rx_buffer_if #(.WIDTH(8)) bus ();

    rx_buffer #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: received bits kept as a list, word formed arithmetically.
    bit       m_bits[$];
    int       m_dout;
    bit       m_valid;
    bit       m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit d, input bit e, input bit a, input bit rdv);
        bit done;
        int w;
        done = 1'b0;
        if (r) begin
            m_bits.delete();
            m_dout  = 0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        if (a) begin
            m_bits.delete();
            m_ovr = 1'b0;
            if (e) m_bits.push_back(d);
        end else if (e) begin
            m_bits.push_back(d);
            if (m_bits.size() == 8) begin
                w = 0;
                foreach (m_bits[i]) w = w * 2 + int'(m_bits[i]);
                if (m_valid && !rdv) m_ovr = 1'b1;
                m_dout  = w;
                m_valid = 1'b1;
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (rdv && !done) m_valid = 1'b0;
    endtask

    // One clock: drive inputs, advance model, sample outputs #1 after the edge.
    task automatic cyc(input bit r, input bit d, input bit e, input bit a, input bit rdv);
        rst       = r;
        bus.din   = d;
        bus.en    = e;
        bus.align = a;
        bus.rd    = rdv;
        model_step(r, d, e, a, rdv);
        @(posedge clk);
        #1;
        chk("dout",    32'(bus.dout),    32'(m_dout));
        chk("valid",   32'(bus.valid),   32'(m_valid));
        chk("busy",    32'(bus.busy),    32'(m_bits.size() != 0));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    endtask

    // Send one word MSB first; optional align on the first bit and random en=0 gaps.
    task automatic send_word(input logic [7:0] w, input bit first_align, input int gap_max);
        logic [7:0] wv;
        int g;
        wv = w;
        for (int i = 7; i >= 0; i--) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int k = 0; k < g; k++) cyc(0, 1'($urandom), 0, 0, 0);
            cyc(0, wv[i], 1, (i == 7) && first_align, 0);
        end
    endtask

    logic [15:0] pair;

    initial begin
        m_dout = 0; m_valid = 0; m_ovr = 0;
        rst = 1; bus.din = 0; bus.en = 0; bus.align = 0; bus.rd = 0;
        @(posedge clk);
        #1;

        // Reset with en=1, din=1
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("rst_dout", 32'(bus.dout), 32'h00);
        cyc(0, 0, 0, 0, 0);
        chk("rst_release_valid", 32'(bus.valid), 32'h0);

        // Single word 0xA5
        send_word(8'hA5, 1, 0);
        chk("a5_dout", 32'(bus.dout), 32'hA5);
        chk("a5_valid", 32'(bus.valid), 32'h1);
        chk("a5_busy", 32'(bus.busy), 32'h0);
        cyc(0, 0, 0, 0, 1);

        // Gapped enable
        for (int rep = 0; rep < 3; rep++) begin
            send_word(8'hA5, 1, 3);
            chk("gap_dout", 32'(bus.dout), 32'hA5);
            cyc(0, 0, 0, 0, 1);
        end

        // Back-to-back 0x3C, 0xC3 with rd two cycles after each valid rise
        pair = 16'h3CC3;
        for (int i = 0; i < 19; i++) begin
            cyc(0, (i < 16) ? pair[15 - i] : 1'b0, i < 16, i == 0, (i == 10) || (i == 18));
            if (i == 7)  chk("b2b_first", 32'(bus.dout), 32'h3C);
            if (i == 15) chk("b2b_second", 32'(bus.dout), 32'hC3);
        end
        chk("b2b_overrun", 32'(bus.overrun), 32'h0);
        chk("b2b_drained", 32'(bus.valid), 32'h0);

        // rd exactly on the completion cycle of 0xC3
        for (int i = 0; i < 16; i++)
            cyc(0, pair[15 - i], 1, i == 0, (i == 10) || (i == 15));
        chk("rdcomp_dout", 32'(bus.dout), 32'hC3);
        chk("rdcomp_valid", 32'(bus.valid), 32'h1);
        chk("rdcomp_ovr", 32'(bus.overrun), 32'h0);
        cyc(0, 0, 0, 0, 1);

        // Overrun
        send_word(8'h11, 1, 0);
        send_word(8'h22, 0, 0);
        chk("ovr_dout", 32'(bus.dout), 32'h22);
        chk("ovr_valid", 32'(bus.valid), 32'h1);
        chk("ovr_set", 32'(bus.overrun), 32'h1);
        cyc(0, 0, 0, 1, 0);
        chk("ovr_clear", 32'(bus.overrun), 32'h0);
        chk("ovr_keep_valid", 32'(bus.valid), 32'h1);
        chk("ovr_keep_dout", 32'(bus.dout), 32'h22);
        cyc(0, 0, 0, 0, 1);

        // Realign mid-word
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, i == 0, 0);
        cyc(0, 0, 1, 1, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, 0);
        chk("realign_dout", 32'(bus.dout), 32'h7F);
        cyc(0, 0, 0, 0, 1);

        // Reset mid-word, then a clean word without align
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, i == 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("rst_mid_busy", 32'(bus.busy), 32'h0);
        send_word(8'h96, 0, 0);
        chk("rst_mid_word", 32'(bus.dout), 32'h96);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 59) == 0), 1'($urandom), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 14) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
